// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Shift-add multiply and restoring divide both run WIDTH iterations on a
// shared pair of working registers; signs are stripped on issue and
// re-applied in a single fix-up cycle before HI/LO are written.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_req,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div0;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_work_hi;
    logic [WIDTH-1:0] r_work_lo;
    logic [WIDTH-1:0] r_opnd_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // FSM control strobes
    logic             w_accept;
    logic             w_iter;
    logic             w_fix;
    logic             w_mt_ok;

    // Issue-time operand conditioning
    logic             w_is_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    // Iteration datapath
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [WIDTH-1:0] w_work_hi_nxt;
    logic [WIDTH-1:0] w_work_lo_nxt;

    // Fix-up results
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = r_busy;
    assign done      = r_done;
    assign stall_out = r_busy & (start | rd_req | hi_we | lo_we);

    // State register; busy is registered alongside so it tracks RUN/FIX exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Next-state logic and per-state control strobes; flush overrides everything
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_iter       = 1'b0;
        w_fix        = 1'b0;
        w_mt_ok      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_mt_ok = 1'b1;
                    if (start) begin
                        w_accept     = 1'b1;
                        w_next_state = S_RUN;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_next_state = S_FIX;
                    end else begin
                        w_next_state = S_RUN;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_fix        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Strip signs on issue: signed ops work on magnitudes, unsigned on raw bits
    always_comb begin
        w_is_signed = ~op[0];
        w_neg_a     = w_is_signed & src_a[WIDTH-1];
        w_neg_b     = w_is_signed & src_b[WIDTH-1];
        if (w_neg_a) begin
            w_mag_a = -src_a;
        end else begin
            w_mag_a = src_a;
        end
        if (w_neg_b) begin
            w_mag_b = -src_b;
        end else begin
            w_mag_b = src_b;
        end
    end

    // One iteration: right-shifting shift-add multiply or left-shifting restoring divide
    always_comb begin
        w_addend  = r_work_lo[0] ? r_opnd_b : {WIDTH{1'b0}};
        w_sum     = {1'b0, r_work_hi} + {1'b0, w_addend};
        w_shift   = {r_work_hi, r_work_lo[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_opnd_b});
        // The partial remainder is always below the divisor, so the low WIDTH bits suffice
        w_rem_sub = w_shift[WIDTH-1:0] - r_opnd_b;
        if (r_op[1]) begin
            w_work_hi_nxt = w_ge ? w_rem_sub : w_shift[WIDTH-1:0];
            w_work_lo_nxt = {r_work_lo[WIDTH-2:0], w_ge};
        end else begin
            w_work_hi_nxt = w_sum[WIDTH:1];
            w_work_lo_nxt = {w_sum[0], r_work_lo[WIDTH-1:1]};
        end
    end

    // Re-apply signs; divide by zero bypasses the datapath result entirely
    always_comb begin
        w_prod = {r_work_hi, r_work_lo};
        if (r_sign_a ^ r_sign_b) begin
            w_prod_fix = -w_prod;
            w_quot_fix = -r_work_lo;
        end else begin
            w_prod_fix = w_prod;
            w_quot_fix = r_work_lo;
        end
        if (r_sign_a) begin
            w_rem_fix = -r_work_hi;
        end else begin
            w_rem_fix = r_work_hi;
        end
        if (r_op[1]) begin
            if (r_div0) begin
                w_res_hi = r_a_raw;
                w_res_lo = {WIDTH{1'b1}};
            end else begin
                w_res_hi = w_rem_fix;
                w_res_lo = w_quot_fix;
            end
        end else begin
            w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    // Operand capture, iteration registers, architectural HI/LO and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_op      <= 2'b00;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_div0    <= 1'b0;
            r_a_raw   <= {WIDTH{1'b0}};
            r_work_hi <= {WIDTH{1'b0}};
            r_work_lo <= {WIDTH{1'b0}};
            r_opnd_b  <= {WIDTH{1'b0}};
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
            r_done    <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_cnt     <= {CNT_W{1'b0}};
                r_op      <= op;
                r_sign_a  <= w_neg_a;
                r_sign_b  <= w_neg_b;
                r_div0    <= op[1] & (src_b == {WIDTH{1'b0}});
                r_a_raw   <= src_a;
                r_work_hi <= {WIDTH{1'b0}};
                // Divide shifts the dividend out of LO; multiply shifts the multiplier out
                if (op[1]) begin
                    r_work_lo <= w_mag_a;
                    r_opnd_b  <= w_mag_b;
                end else begin
                    r_work_lo <= w_mag_b;
                    r_opnd_b  <= w_mag_a;
                end
            end else if (w_iter) begin
                r_cnt     <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_work_hi <= w_work_hi_nxt;
                r_work_lo <= w_work_lo_nxt;
            end
            // An MTHI/MTLO issued with start lands now and is overwritten at FIX
            if (w_fix) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_mt_ok) begin
                if (hi_we) begin
                    r_hi <= wdata;
                end
                if (lo_we) begin
                    r_lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected {hi,lo}
// pushed at issue and popped when done is seen.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_req;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_out;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .rd_req(rd_req),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_out(stall_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference results from language arithmetic, plus the two architected corner cases
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [63:0] up;
        case (o)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                return up;
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one op from IDLE, wait (bounded) for done, report latency and result
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] ohi, output logic [31:0] olo,
                          output logic tail);
        op = o; src_a = a; src_b = b; start = 1'b1;
        sb_q.push_back(model(o, a, b));
        tick;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        ohi = hi;
        olo = lo;
        tick;
        tail = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; op = 2'b00; src_a = 32'h5; src_b = 32'h3;
        rd_req = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678; flush = 1'b0;
        tick; tick;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b want 0/0", busy, done); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: stall_out=%b want 0", stall_out); end
        start = 1'b0; rd_req = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_mult;
        int lat; logic [31:0] h; logic [31:0] l; logic t; logic [63:0] exp_v;
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, lat, h, l, t);
        exp_v = sb_q.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if ({h, l} !== exp_v) begin errors++; $display("FAIL mult_result: got %h_%h want %h", h, l, exp_v); end
        checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_const: got %h_%h want ffffffff_fffffffe", h, l); end
        checks++; if (t !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: done=%b one cycle later, want 0", t); end
    endtask

    task automatic test_multu;
        int lat; logic [31:0] h; logic [31:0] l; logic t; logic [63:0] exp_v;
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat, h, l, t);
        exp_v = sb_q.pop_front();
        checks++; if ({h, l} !== exp_v || h !== 32'h1) begin errors++; $display("FAIL multu_result: got %h_%h want %h", h, l, exp_v); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
    endtask

    task automatic test_div;
        int lat; logic [31:0] h; logic [31:0] l; logic t; logic [63:0] exp_v;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, h, l, t);
        exp_v = sb_q.pop_front();
        checks++; if ({h, l} !== exp_v || l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7_by_2: got %h_%h want %h", h, l, exp_v); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l, t);
        exp_v = sb_q.pop_front();
        checks++; if ({h, l} !== exp_v || l !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h_%h want %h", h, l, exp_v); end
    endtask

    task automatic test_div0;
        int lat; logic [31:0] h; logic [31:0] l; logic t; logic [63:0] exp_v;
        run_op(2'b11, 32'h0000_0007, 32'h0, lat, h, l, t);
        exp_v = sb_q.pop_front();
        checks++; if ({h, l} !== exp_v || h !== 32'h7) begin errors++; $display("FAIL divu_by_zero: got %h_%h want %h", h, l, exp_v); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0, lat, h, l, t);
        exp_v = sb_q.pop_front();
        checks++; if ({h, l} !== exp_v || h !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_by_zero: got %h_%h want %h", h, l, exp_v); end
    endtask

    task automatic test_mt_with_start;
        int n; logic [63:0] exp_v;
        op = 2'b01; src_a = 32'h2; src_b = 32'h3; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        sb_q.push_back(model(2'b01, 32'h2, 32'h3));
        tick;
        start = 1'b0; hi_we = 1'b0;
        checks++; if (hi !== 32'hAAAA_5555 || busy !== 1'b1) begin errors++; $display("FAIL mt_with_start: hi=%h busy=%b want aaaa5555/1", hi, busy); end
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick; n++; end
        exp_v = sb_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL mt_overwritten: got %h_%h want %h", hi, lo, exp_v); end
        tick;
    endtask

    task automatic test_back_to_back;
        int n; int bad; logic [63:0] exp_v;
        hi_we = 1'b1; wdata = 32'h1111_1111; tick; hi_we = 1'b0;
        lo_we = 1'b1; wdata = 32'h2222_2222; tick; lo_we = 1'b0;
        checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin errors++; $display("FAIL mt_idle: hi=%h lo=%h want 11111111/22222222", hi, lo); end
        op = 2'b01; src_a = 32'h3; src_b = 32'h5; start = 1'b1;
        sb_q.push_back(model(2'b01, 32'h3, 32'h5));
        tick;
        start = 1'b0;
        n = 0;
        repeat (5) begin tick; n++; end
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1; rd_req = 1'b1;
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL stall_assert: stall_out=%b want 1", stall_out); end
        tick; n++;
        lo_we = 1'b0;
        checks++; if (lo !== 32'h2222_2222 || hi !== 32'h1111_1111) begin errors++; $display("FAIL mtlo_busy_ignored: hi=%h lo=%h want 11111111/22222222", hi, lo); end
        bad = 0;
        while (done !== 1'b1 && n < 40) begin
            if (stall_out !== 1'b1) bad++;
            tick; n++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_held: %0d busy cycles without stall, want 0", bad); end
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", n); end
        checks++; if (stall_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_release: stall_out=%b busy=%b want 0/0", stall_out, busy); end
        exp_v = sb_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL b2b_first: got %h_%h want %h", hi, lo, exp_v); end
        sb_q.push_back(model(2'b11, 32'd100, 32'd7));
        tick;
        start = 1'b0; rd_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick; n++; end
        exp_v = sb_q.pop_front();
        checks++; if ({hi, lo} !== exp_v || n !== 33) begin errors++; $display("FAIL b2b_second: got %h_%h lat %0d want %h lat 33", hi, lo, n, exp_v); end
        tick;
    endtask

    task automatic test_flush;
        int pulses;
        hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h0BAD_F00D; tick;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h1234_5678; tick; lo_we = 1'b0;
        op = 2'b00; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_run_busy: busy=%b want 0", busy); end
        checks++; if (hi !== 32'h0BAD_F00D || lo !== 32'h1234_5678) begin errors++; $display("FAIL flush_hilo: hi=%h lo=%h want 0badf00d/12345678", hi, lo); end
        pulses = 0;
        repeat (40) begin if (done === 1'b1) pulses++; tick; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_done: %0d pulses want 0", pulses); end
        flush = 1'b1; start = 1'b1; hi_we = 1'b1; wdata = 32'hFFFF_0000;
        tick;
        flush = 1'b0; start = 1'b0; hi_we = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'h0BAD_F00D) begin errors++; $display("FAIL flush_idle: busy=%b hi=%h want 0/0badf00d", busy, hi); end
        tick;
    endtask

    task automatic test_reset_mid;
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        rst_n = 1'b0;
        tick;
        checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_random;
        int lat; logic [31:0] h; logic [31:0] l; logic t; logic [63:0] exp_v;
        logic [1:0] o; logic [31:0] a; logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = -32'($urandom_range(1, 255));
                default: b = {16'h0, 16'($urandom)};
            endcase
            run_op(o, a, b, lat, h, l, t);
            exp_v = sb_q.pop_front();
            checks++; if ({h, l} !== exp_v || lat !== 33 || t !== 1'b0) begin errors++; $display("FAIL random_op%0d: op=%0d a=%h b=%h got %h_%h lat %0d want %h lat 33", i, o, a, b, h, l, lat, exp_v); end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_div0;
        test_mt_with_start;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
